mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Parametrised, multi-cycle integer multiply/divide unit, companion to the single-cycle ALU in the execute stage.
- Owns the architectural HI/LO register pair.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, under a start/busy/done handshake.
- Also executes single-cycle MTHI/MTLO writes.
- The pipeline stalls on busy and reads HI/LO directly for MFHI/MFLO.

Parameters:
- DATA_WIDTH, 32, operand, HI and LO width; must be at least 4.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, width of the iteration counter (derived, not overridden).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only when the FSM is IDLE.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no-op).
- srcA  input  DATA_WIDTH  multiplicand / dividend / MTHI-MTLO data.
- srcB  input  DATA_WIDTH  multiplier / divisor.
- busy  output  1  high while an iterative operation runs.
- done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- hi  output  DATA_WIDTH  HI register.
- lo  output  DATA_WIDTH  LO register.

Behaviour:
- Reset: when rst is sampled low, hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0.
  - Reset overrides every other input, including mid-operation; the aborted operation produces no done.
- FSM states: IDLE, RUN.
  - IDLE -> RUN: start=1 and op in 0..3. Latch operand magnitudes and sign flags (signed ops only); counter=DATA_WIDTH.
  - IDLE, start=1, op=4/5: hi (or lo) <= srcA at that edge; stay IDLE; no busy, no done.
  - IDLE, reserved op: ignored.
  - RUN: one iteration per cycle; counter decrements.
  - RUN -> IDLE: on the edge where counter reaches 1. At that edge hi/lo are written with the sign-corrected result and done is set to 1 for exactly one cycle.
- busy equals (state==RUN), registered.
- start is ignored while busy=1; the requester must hold or reissue it.
- done coincides with the first IDLE cycle. A start sampled in that cycle is accepted, so back-to-back operations are supported.
- Latency: start sampled at edge 0 gives busy=1 in cycles 1..DATA_WIDTH and done=1 in cycle DATA_WIDTH+1 (33 for the default).
- hi/lo keep their previous values throughout RUN; intermediate values are never visible.
- Multiply: shift-add on unsigned magnitudes into a 2*DATA_WIDTH accumulator.
  - {hi,lo} = full product.
  - Signed: negate the 2W product if the operand signs differ.
- Divide: restoring shift-subtract on magnitudes.
  - lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - DIV of most-negative by -1: lo = most-negative, hi = 0 (no trap).
- Divide by zero (DIV or DIVU): full latency; lo = all ones, hi = srcA as latched; no sign correction.
- Operands are captured at start; srcA/srcB may change during RUN without effect.

Decomposition:
- Add to the shared types include: MD_CODE_MULT/MULTU/DIV/DIVU/MTHI/MTLO constants, MDCodePath (3-bit) macro, MD state encoding.
- Sub-module md_iter_step (combinational):
  - One multiply or divide iteration.
  - Inputs: accumulator/remainder, operand, mode.
  - Outputs: next accumulator, quotient bit.
- mul_div_unit owns the FSM, counter, sign correction and HI/LO.

Test Plan:
1. MULTU 0xFFFFFFFF*0xFFFFFFFF, start at cycle 0 -> busy cycles 1..32, done only in cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
2. MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
3. DIVU 100/0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV -5/0 -> lo=0xFFFFFFFF, hi=0xFFFFFFFB.
4. MTHI 0x1234 then MTLO 0xABCD in consecutive cycles -> hi=0x1234 and lo=0xABCD one edge after each, busy/done stay 0. Start MULTU 2*3 while busy, with srcA/srcB changing during RUN -> ignored; first result unchanged.
5. Reset low at cycle 10 of a DIVU -> next cycle busy=0, hi=lo=0, no done pulse.
6. Back-to-back: MULTU 6*7, then DIVU 100/7 issued in the done cycle -> first done shows lo=42, hi=0. Second done 33 cycles later shows lo=14, hi=2.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared types and operation codes for the iterative multiply/divide unit.
// Holds the op-code path type, the op constants and the FSM state encoding.
package mul_div_unit_pkg;

   typedef logic [2:0] md_code_t;

   localparam md_code_t MD_CODE_MULT  = 3'd0;
   localparam md_code_t MD_CODE_MULTU = 3'd1;
   localparam md_code_t MD_CODE_DIV   = 3'd2;
   localparam md_code_t MD_CODE_DIVU  = 3'd3;
   localparam md_code_t MD_CODE_MTHI  = 3'd4;
   localparam md_code_t MD_CODE_MTLO  = 3'd5;

   typedef enum logic {
      MD_IDLE,
      MD_RUN
   } md_state_t;

   function automatic logic is_iter_op(input md_code_t code);
      return (code == MD_CODE_MULT) || (code == MD_CODE_MULTU) ||
             (code == MD_CODE_DIV)  || (code == MD_CODE_DIVU);
   endfunction

   function automatic logic is_signed_op(input md_code_t code);
      return (code == MD_CODE_MULT) || (code == MD_CODE_DIV);
   endfunction

endpackage

// File: rtl/mul_div_unit_md_iter_step.sv
// One combinational iteration: MSB-first shift-add multiply or restoring divide.
// For divide only the low DATA_WIDTH bits of the accumulator hold the remainder.
module md_iter_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2*DATA_WIDTH-1:0] acc,
   input  logic [DATA_WIDTH-1:0]   operand,
   input  logic                    in_bit,
   input  logic                    is_div,
   output logic [2*DATA_WIDTH-1:0] acc_next,
   output logic                    q_bit
);

   logic [DATA_WIDTH:0]     trial;
   logic [DATA_WIDTH-1:0]   diff;
   logic [2*DATA_WIDTH-1:0] addend;

   always_comb begin
      trial    = {acc[DATA_WIDTH-1:0], in_bit};
      diff     = trial[DATA_WIDTH-1:0] - operand;
      addend   = '0;
      acc_next = '0;
      q_bit    = 1'b0;
      if (is_div) begin
         // Remainder stays below the divisor, so the subtraction fits in DATA_WIDTH bits.
         if (trial >= {1'b0, operand}) begin
            q_bit                    = 1'b1;
            acc_next[DATA_WIDTH-1:0] = diff;
         end else begin
            acc_next[DATA_WIDTH-1:0] = trial[DATA_WIDTH-1:0];
         end
      end else begin
         if (in_bit) addend[DATA_WIDTH-1:0] = operand;
         acc_next = (acc << 1) + addend;
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one bit per cycle,
// with single-cycle MTHI/MTLO and a start/busy/done handshake.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] srcA,
   input  logic [DATA_WIDTH-1:0] srcB,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

   md_state_t               state, state_next;
   logic [CNT_WIDTH-1:0]    count;
   logic [2*DATA_WIDTH-1:0] acc, step_acc, prod;
   logic [DATA_WIDTH-1:0]   opnd, shreg, quot, rem;
   logic                    step_q, is_div, neg_res, neg_rem, div_zero;
   logic                    a_neg_in, b_neg_in, last;

   md_iter_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .acc      (acc),
      .operand  (opnd),
      .in_bit   (shreg[DATA_WIDTH-1]),
      .is_div   (is_div),
      .acc_next (step_acc),
      .q_bit    (step_q)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= MD_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         MD_IDLE: if (start && is_iter_op(op)) state_next = MD_RUN;
         MD_RUN:  if (last) state_next = MD_IDLE;
      endcase
   end

   always_comb begin
      last     = (count == CNT_WIDTH'(1));
      a_neg_in = is_signed_op(op) & srcA[DATA_WIDTH-1];
      b_neg_in = is_signed_op(op) & srcB[DATA_WIDTH-1];
      prod     = neg_res ? -step_acc : step_acc;
      quot     = {shreg[DATA_WIDTH-2:0], step_q};
      rem      = step_acc[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         count    <= '0;
         acc      <= '0;
         opnd     <= '0;
         shreg    <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         busy <= (state_next == MD_RUN);
         done <= 1'b0;
         case (state)
            MD_IDLE: begin
               if (start) begin
                  if (is_iter_op(op)) begin
                     acc      <= '0;
                     opnd     <= b_neg_in ? -srcB : srcB;
                     shreg    <= a_neg_in ? -srcA : srcA;
                     is_div   <= op[1];
                     neg_res  <= a_neg_in ^ b_neg_in;
                     neg_rem  <= a_neg_in;
                     div_zero <= (srcB == '0);
                     count    <= CNT_WIDTH'(DATA_WIDTH);
                  end else if (op == MD_CODE_MTHI) begin
                     hi <= srcA;
                  end else if (op == MD_CODE_MTLO) begin
                     lo <= srcA;
                  end
               end
            end
            MD_RUN: begin
               acc   <= step_acc;
               shreg <= {shreg[DATA_WIDTH-2:0], step_q};
               count <= count - 1'b1;
               if (last) begin
                  done <= 1'b1;
                  if (!is_div) begin
                     {hi, lo} <= prod;
                  end else begin
                     // With a zero divisor the remainder shifts in the dividend magnitude
                     // unchanged, so the dividend-sign correction restores srcA exactly.
                     hi <= neg_rem ? -rem : rem;
                     lo <= div_zero ? '1 : (neg_res ? -quot : quot);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized
// operations against a plain-arithmetic reference model of HI/LO.
module tb_mul_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] src_a, src_b;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   always #5 clk = ~clk;

   mul_div_unit #(.DATA_WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .srcA  (src_a),
      .srcB  (src_b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference {hi,lo}: 64-bit signed arithmetic truncates toward zero and also
   // yields the wrapped most-negative / -1 quotient naturally.
   function automatic logic [63:0] ref_result(input logic [2:0] code,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
      longint      sa, sb, q, r;
      logic [63:0] res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      res = {m_hi, m_lo};
      case (code)
         3'd0: res = 64'(sa * sb);
         3'd1: res = {32'b0, a} * {32'b0, b};
         3'd2: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         3'd3: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else        res = {a % b, a / b};
         end
         default: res = {m_hi, m_lo};
      endcase
      return res;
   endfunction

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0: v = '0;
         1: v = 1;
         2: v = '1;
         3: v = 32'h8000_0000;
         4: v = W'($urandom_range(0, 15));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Called at a negedge; returns at the negedge of the done cycle so a following
   // call issues its start in the done cycle (back-to-back).
   task automatic run_iter(input logic [2:0] code, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit inject);
      logic [63:0] exp;
      int cyc, bad;
      exp   = ref_result(code, a, b);
      start = 1'b1; op = code; src_a = a; src_b = b;
      @(negedge clk);
      cyc = 1; bad = 0;
      while (!done && cyc < 100) begin
         if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) bad++;
         if (inject && cyc == 5) begin
            start = 1'b1; op = 3'd1; src_a = 2; src_b = 3;
         end else begin
            start = 1'b0; src_a = $urandom; src_b = $urandom;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check("latency", 64'(cyc), 64'd33);
      check("run_busy_and_hold", 64'(bad), 64'd0);
      check("busy_at_done", 64'(busy), 64'd0);
      check("result", {hi, lo}, exp);
      {m_hi, m_lo} = exp;
   endtask

   task automatic run_mt(input logic [2:0] code, input logic [W-1:0] a);
      start = 1'b1; op = code; src_a = a; src_b = $urandom;
      @(negedge clk);
      start = 1'b0;
      if (code == 3'd4) m_hi = a;
      if (code == 3'd5) m_lo = a;
      check("mt_regs", {hi, lo}, {m_hi, m_lo});
      check("mt_busy_done", 64'({busy, done}), 64'd0);
   endtask

   initial begin
      bit seen_done;
      rst = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
      repeat (3) @(negedge clk);
      check("reset_regs", {hi, lo}, 64'd0);
      check("reset_busy_done", 64'({busy, done}), 64'd0);
      rst = 1'b1;

      run_iter(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_iter(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);
      run_iter(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_iter(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_iter(3'd3, 32'd100, 32'd0, 1'b0);
      run_iter(3'd2, 32'hFFFF_FFFB, 32'd0, 1'b0);
      run_mt(3'd4, 32'h1234);
      run_mt(3'd5, 32'hABCD);
      run_mt(3'd6, 32'hDEAD_BEEF);
      run_iter(3'd1, 32'd6, 32'd7, 1'b0);
      run_iter(3'd3, 32'd100, 32'd7, 1'b0);
      @(negedge clk);
      check("done_single_pulse", 64'(done), 64'd0);

      start = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      m_hi = '0; m_lo = '0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_regs", {hi, lo}, 64'd0);
      rst = 1'b1;
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("abort_no_done", 64'(seen_done), 64'd0);

      for (int i = 0; i < 40; i++) begin
         if (i % 9 == 4) run_mt(3'($urandom_range(4, 5)), $urandom);
         else            run_iter(3'($urandom_range(0, 3)), pick(), pick(), (i % 7) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
